// File: rtl/naive_bus_arbiter_2m_if.sv
// naive_bus: single-cycle request/grant bus with
// one-cycle read return, shared by masters and slaves.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [3:0]  rd_be;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [3:0]  wr_be;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output rd_req, rd_be, rd_addr,
    output wr_req, wr_be, wr_addr, wr_data,
    input  rd_gnt, wr_gnt, rd_data
  );

  modport slave (
    input  rd_req, rd_be, rd_addr,
    input  wr_req, wr_be, wr_addr, wr_data,
    output rd_gnt, wr_gnt, rd_data
  );
endinterface

// File: rtl/naive_bus_arbiter_2m.sv
// Two-master naive_bus arbiter: round-robin with a
// bounded burst lock, one-cycle steered read return.
module naive_bus_arbiter_2m #(
  parameter int unsigned MAX_BURST    = 4,
  parameter bit          RD_ZERO_FILL = 1'b1
) (
  input  logic    clk,
  input  logic    rst_n,
  naive_bus.slave  bus_slave0,
  naive_bus.slave  bus_slave1,
  naive_bus.master bus_master,
  output logic    o_owner,
  output logic    o_busy
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  logic       req0;
  logic       req1;
  logic       both;
  logic       active;
  logic       win;
  logic       last;
  logic [3:0] burst_cnt;
  logic [3:0] burst_nxt;
  logic       rd_valid;
  logic       rd_fire;
  logic       ret_ok;
  logic [31:0] fill;

  assign req0   = bus_slave0.rd_req | bus_slave0.wr_req;
  assign req1   = bus_slave1.rd_req | bus_slave1.wr_req;
  assign both   = req0 & req1;
  assign active = rst_n & (req0 | req1);
  assign o_busy = active;

  // A zero count means no lock is held: the
  // contest falls back to plain round-robin.
  always_comb begin
    win = 1'b0;
    if (both) begin
      if (burst_cnt == 4'd0 || burst_cnt >= MAX_B)
        win = ~last;
      else
        win = last;
    end else begin
      win = req1;
    end
  end

  always_comb begin
    burst_nxt = 4'd1;
    if (both && (win == last)) begin
      if (burst_cnt == 4'hF)
        burst_nxt = 4'hF;
      else
        burst_nxt = burst_cnt + 4'd1;
    end
  end

  always_comb begin
    bus_master.rd_req  = 1'b0;
    bus_master.rd_be   = '0;
    bus_master.rd_addr = '0;
    bus_master.wr_req  = 1'b0;
    bus_master.wr_be   = '0;
    bus_master.wr_addr = '0;
    bus_master.wr_data = '0;
    if (active) begin
      if (win) begin
        bus_master.rd_req  = bus_slave1.rd_req;
        bus_master.rd_be   = bus_slave1.rd_be;
        bus_master.rd_addr = bus_slave1.rd_addr;
        bus_master.wr_req  = bus_slave1.wr_req;
        bus_master.wr_be   = bus_slave1.wr_be;
        bus_master.wr_addr = bus_slave1.wr_addr;
        bus_master.wr_data = bus_slave1.wr_data;
      end else begin
        bus_master.rd_req  = bus_slave0.rd_req;
        bus_master.rd_be   = bus_slave0.rd_be;
        bus_master.rd_addr = bus_slave0.rd_addr;
        bus_master.wr_req  = bus_slave0.wr_req;
        bus_master.wr_be   = bus_slave0.wr_be;
        bus_master.wr_addr = bus_slave0.wr_addr;
        bus_master.wr_data = bus_slave0.wr_data;
      end
    end
  end

  assign bus_slave0.rd_gnt =
    active & ~win & bus_master.rd_gnt;
  assign bus_slave0.wr_gnt =
    active & ~win & bus_master.wr_gnt;
  assign bus_slave1.rd_gnt =
    active & win & bus_master.rd_gnt;
  assign bus_slave1.wr_gnt =
    active & win & bus_master.wr_gnt;

  assign rd_fire =
    bus_master.rd_req & bus_master.rd_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last      <= 1'b1;
      burst_cnt <= 4'd0;
      o_owner   <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      if (active) begin
        last      <= win;
        burst_cnt <= burst_nxt;
      end else begin
        burst_cnt <= 4'd0;
      end
      if (rd_fire) begin
        o_owner  <= win;
        rd_valid <= 1'b1;
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end

  // Returns in flight across a reset are dropped.
  assign ret_ok = rd_valid & rst_n;
  assign fill   = RD_ZERO_FILL ? 32'd0
                               : bus_master.rd_data;

  assign bus_slave0.rd_data =
    (ret_ok & ~o_owner) ? bus_master.rd_data : fill;
  assign bus_slave1.rd_data =
    (ret_ok & o_owner) ? bus_master.rd_data : fill;

endmodule

// File: tb/tb_naive_bus_arbiter_2m.sv
// Directed bench: per-cycle vectors queued to a
// scoreboard, checked by a negedge monitor.
module tb_naive_bus_arbiter_2m;

  typedef struct {
    bit          rst;
    bit          r0, w0, r1, w1, sg;
    logic [31:0] a0, a1;
    bit          g0, g1, by, wr, own;
    logic [31:0] d0, d1;
    int          bc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sg = 1'b1;
  logic o_owner;
  logic o_busy;

  naive_bus s0();
  naive_bus s1();
  naive_bus m();

  naive_bus_arbiter_2m #(
    .MAX_BURST(4),
    .RD_ZERO_FILL(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_slave0(s0),
    .bus_slave1(s1),
    .bus_master(m),
    .o_owner(o_owner),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] ram(
    input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hA000_0000 | a;
  endfunction

  assign m.rd_gnt = sg;
  assign m.wr_gnt = sg;

  always @(posedge clk) begin
    if (m.wr_req && sg) mem[m.wr_addr] = m.wr_data;
    if (m.rd_req && sg) m.rd_data <= ram(m.rd_addr);
    else m.rd_data <= 32'hBAD0_BAD0;
  end

  vec_t vecs[$];
  vec_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic add(
    input bit rst, r0, w0, r1, w1, s,
    input logic [31:0] a0, a1,
    input bit g0, g1, by, wr, own,
    input logic [31:0] d0, d1,
    input int bc);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0;
    v.r1 = r1; v.w1 = w1; v.sg = s;
    v.a0 = a0; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.by = by;
    v.wr = wr; v.own = own;
    v.d0 = d0; v.d1 = d1; v.bc = bc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int i,
    input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec%0d got %h want %h",
        nm, i, act, exp);
    end
  endtask

  int vidx = 0;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      vec_t v;
      v = sb.pop_front();
      chk("gnt0", vidx, 32'(s0.rd_gnt | s0.wr_gnt),
        32'(v.g0));
      chk("gnt1", vidx, 32'(s1.rd_gnt | s1.wr_gnt),
        32'(v.g1));
      chk("busy", vidx, 32'(o_busy), 32'(v.by));
      chk("fwd_wr", vidx, 32'(m.wr_req), 32'(v.wr));
      chk("owner", vidx, 32'(o_owner), 32'(v.own));
      chk("rd_data0", vidx, s0.rd_data, v.d0);
      chk("rd_data1", vidx, s1.rd_data, v.d1);
      chk("burst_cnt", vidx, 32'(dut.burst_cnt),
        32'(v.bc));
      vidx++;
    end
  end

  initial begin
    s0.rd_req = 0; s0.wr_req = 0;
    s1.rd_req = 0; s1.wr_req = 0;
    s0.rd_be = 4'hF; s0.wr_be = 4'hF;
    s1.rd_be = 4'hF; s1.wr_be = 4'hF;
    s0.rd_addr = 0; s0.wr_addr = 0;
    s1.rd_addr = 0; s1.wr_addr = 0;
    s0.wr_data = 32'h5555_5555;
    s1.wr_data = 32'hDEAD_BEEF;

    // reset and single-master reads
    add(0,1,0,1,0,1,0,0, 0,0,0,0,0,0,0,0);
    add(1,1,0,0,0,1,'h0,0, 1,0,1,0,0,0,0,0);
    add(1,1,0,0,0,1,'h4,0,
        1,0,1,0,0,'hA0000000,0,1);
    add(1,1,0,0,0,1,'h8,0,
        1,0,1,0,0,'hA0000004,0,1);
    add(1,0,0,0,0,1,0,0,
        0,0,0,0,0,'hA0000008,0,1);
    // m1 write beats m0 read, m0 retries
    add(1,1,0,0,1,1,'h1000,'h1000,
        0,1,1,1,0,0,0,0);
    add(1,1,0,0,0,1,'h1000,0, 1,0,1,0,0,0,0,1);
    add(1,0,0,0,0,1,0,0,
        0,0,0,0,0,'hDEADBEEF,0,1);
    // m1 streams, then m0 alone
    add(1,0,0,1,0,1,0,'h10, 0,1,1,0,0,0,0,0);
    add(1,0,0,1,0,1,0,'h14,
        0,1,1,0,1,0,'hA0000010,1);
    add(1,0,0,1,0,1,0,'h18,
        0,1,1,0,1,0,'hA0000014,1);
    add(1,1,0,0,0,1,'h20,0,
        1,0,1,0,1,0,'hA0000018,1);
    add(1,0,0,0,0,1,0,0,
        0,0,0,0,0,'hA0000020,0,1);
    add(0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0,0);
    // continuous contest
    add(1,1,0,1,0,1,'h100,'h200,
        1,0,1,0,0,0,0,0);
    for (int k = 1; k <= 3; k++)
      add(1,1,0,1,0,1,'h100,'h200,
          1,0,1,0,0,'hA0000100,0,k);
    add(1,1,0,1,0,1,'h100,'h200,
        0,1,1,0,0,'hA0000100,0,4);
    for (int k = 1; k <= 3; k++)
      add(1,1,0,1,0,1,'h100,'h200,
          0,1,1,0,1,0,'hA0000200,k);
    add(1,1,0,1,0,1,'h100,'h200,
        1,0,1,0,1,0,'hA0000200,4);
    // slave stalls six cycles
    add(1,1,0,1,0,0,'h100,'h200,
        0,0,1,0,0,'hA0000100,0,1);
    add(1,1,0,1,0,0,'h100,'h200, 0,0,1,0,0,0,0,2);
    add(1,1,0,1,0,0,'h100,'h200, 0,0,1,0,0,0,0,3);
    add(1,1,0,1,0,0,'h100,'h200, 0,0,1,0,0,0,0,4);
    add(1,1,0,1,0,0,'h100,'h200, 0,0,1,0,0,0,0,1);
    add(1,1,0,1,0,0,'h100,'h200, 0,0,1,0,0,0,0,2);
    // reset while a read is in flight
    add(1,1,0,0,0,1,'h300,0, 1,0,1,0,0,0,0,3);
    add(0,1,0,1,0,1,'h100,'h200, 0,0,0,0,0,0,0,1);
    add(1,1,0,1,0,1,'h100,'h200, 1,0,1,0,0,0,0,0);
    add(1,0,0,0,0,1,0,0,
        0,0,0,0,0,'hA0000100,0,1);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst_n = vecs[i].rst;
      sg = vecs[i].sg;
      s0.rd_req = vecs[i].r0;
      s0.wr_req = vecs[i].w0;
      s0.rd_addr = vecs[i].a0;
      s0.wr_addr = vecs[i].a0;
      s1.rd_req = vecs[i].r1;
      s1.wr_req = vecs[i].w1;
      s1.rd_addr = vecs[i].a1;
      s1.wr_addr = vecs[i].a1;
      sb.push_back(vecs[i]);
    end
    for (int t = 0; t < 5 && sb.size() != 0; t++)
      @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d want 0",
        sb.size());
    end
    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
